// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB3 types and constants for completer and master
package apb_pkg;

    // Bus phase tracked by the completer FSM
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15)
    localparam int WAIT_W = 4;

endpackage

// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB3 bus bundle for one select line
interface apb_slave_mem_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - flop-array storage, one write port, one async read port
module apb_slave_regfile #(
    parameter int DEPTH      = 8,
    parameter int IDX_W      = 3,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage array: cleared on reset, single word written when we is high
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB3 completer with word memory, wait states and read-only top region
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 4,
    parameter int          DATA_WIDTH  = 4,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned RO_BASE     = 2 ** (ADDR_WIDTH - 1)
) (
    input  logic             pclk,
    input  logic             presetn,
    apb_slave_mem_if.slave   apb
);

    localparam int IDX_W = ADDR_WIDTH - 1;
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    apb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [IDX_W-1:0]      idx;
    logic [31:0]           idx_ext;
    logic                  in_access;
    logic                  ready;
    logic                  ro_hit;
    logic                  we;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  unused_addr_msb;

    // The MSB selects between MEM instances upstream, so it aliases here
    assign idx             = apb.paddr[IDX_W-1:0];
    assign unused_addr_msb = apb.paddr[ADDR_WIDTH-1];
    assign idx_ext         = 32'(idx);

    // SETUP means "setup phase seen last cycle": with psel & penable present it
    // is already the first access cycle, which gives completion at 1+WAIT_CYCLES
    assign in_access = apb.psel & apb.penable & ((state_q == ACCESS) | (state_q == SETUP));
    assign ready     = in_access & (wait_cnt_q == '0);
    assign ro_hit    = (idx_ext >= RO_BASE);
    assign we        = ready & apb.pwrite & ~ro_hit;

    assign apb.pready  = ready;
    assign apb.pslverr = ready & apb.pwrite & ro_hit;
    assign apb.prdata  = (ready & ~apb.pwrite) ? rdata : '0;

    // Phase register and wait-state counter
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next phase: track setup/access, abort on dropped psel, reload counter per transfer
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d    = SETUP;
                    wait_cnt_d = WAIT_INIT;
                end
            end
            SETUP, ACCESS: begin
                if (!(apb.psel && apb.penable)) begin
                    state_d = IDLE;
                end else if (ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                    if (wait_cnt_q != '0) begin
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    apb_slave_regfile #(
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (we),
        .widx    (idx),
        .wdata   (apb.pwdata),
        .ridx    (idx),
        .rdata   (rdata)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed self-checking bench for apb_slave_mem
module tb_apb_slave_mem;

    logic       pclk = 1'b0;
    logic       presetn;
    logic [3:0] sel;
    logic       penable;
    logic       pwrite;
    logic [3:0] paddr;
    logic [3:0] pwdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    apb_slave_mem_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) if0 ();
    apb_slave_mem_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) if1 ();
    apb_slave_mem_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) if2 ();
    apb_slave_mem_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) if3 ();

    assign if0.psel = sel[0];
    assign if1.psel = sel[1];
    assign if2.psel = sel[2];
    assign if3.psel = sel[3];
    assign if0.penable = penable;
    assign if1.penable = penable;
    assign if2.penable = penable;
    assign if3.penable = penable;
    assign if0.pwrite = pwrite;
    assign if1.pwrite = pwrite;
    assign if2.pwrite = pwrite;
    assign if3.pwrite = pwrite;
    assign if0.paddr = paddr;
    assign if1.paddr = paddr;
    assign if2.paddr = paddr;
    assign if3.paddr = paddr;
    assign if0.pwdata = pwdata;
    assign if1.pwdata = pwdata;
    assign if2.pwdata = pwdata;
    assign if3.pwdata = pwdata;

    logic       rdy [4];
    logic       err [4];
    logic [3:0] rd  [4];
    assign rdy[0] = if0.pready;
    assign rdy[1] = if1.pready;
    assign rdy[2] = if2.pready;
    assign rdy[3] = if3.pready;
    assign err[0] = if0.pslverr;
    assign err[1] = if1.pslverr;
    assign err[2] = if2.pslverr;
    assign err[3] = if3.pslverr;
    assign rd[0]  = if0.prdata;
    assign rd[1]  = if1.prdata;
    assign rd[2]  = if2.prdata;
    assign rd[3]  = if3.prdata;

    // 0: zero wait, 1: three waits, 2: read-only from index 6, 3: two waits
    apb_slave_mem #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .presetn(presetn), .apb(if0.slave));
    apb_slave_mem #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .presetn(presetn), .apb(if1.slave));
    apb_slave_mem #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .WAIT_CYCLES(0), .RO_BASE(6)) u_ro (
        .pclk(pclk), .presetn(presetn), .apb(if2.slave));
    apb_slave_mem #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .WAIT_CYCLES(2)) u_w2 (
        .pclk(pclk), .presetn(presetn), .apb(if3.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        sel     = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
    endtask

    // Called just after a rising edge; returns just after the edge that ends the transfer
    task automatic xfer(input int d, input logic wr, input logic [3:0] addr,
                        input logic [3:0] data, input int waits,
                        input logic exp_err, input logic [3:0] exp_rd, input string tag);
        sel     = '0;
        sel[d]  = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge pclk);
        chk({tag, ".setup_rdy"}, 32'(rdy[d]), 32'd0);
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int k = 0; k <= waits; k++) begin
            @(negedge pclk);
            if (k < waits) begin
                chk({tag, ".wait_rdy"}, 32'(rdy[d]), 32'd0);
                @(posedge pclk); #1;
            end else begin
                chk({tag, ".rdy"}, 32'(rdy[d]), 32'd1);
                chk({tag, ".err"}, 32'(err[d]), 32'(exp_err));
                if (!wr) chk({tag, ".rdata"}, 32'(rd[d]), 32'(exp_rd));
            end
        end
        @(posedge pclk); #1;
        bus_idle();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
        end
    endtask

    initial begin
        bus_idle();
        presetn = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst.rdy0", 32'(rdy[0]), 32'd0);
        chk("rst.err0", 32'(err[0]), 32'd0);
        chk("rst.rd0",  32'(rd[0]),  32'd0);
        chk("rst.rdy1", 32'(rdy[1]), 32'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        idle_cycles(1);

        // Zero-wait write then read
        xfer(0, 1'b1, 4'h1, 4'h5, 0, 1'b0, 4'h0, "w0.wr1");
        idle_cycles(1);
        xfer(0, 1'b0, 4'h1, 4'h0, 0, 1'b0, 4'h5, "w0.rd1");
        idle_cycles(1);

        // Three wait states
        xfer(1, 1'b1, 4'h2, 4'hA, 3, 1'b0, 4'h0, "w3.wr2");
        idle_cycles(1);
        xfer(1, 1'b0, 4'h2, 4'h0, 3, 1'b0, 4'hA, "w3.rd2");
        idle_cycles(1);

        // Read-only region boundary: 5 writable, 6 and 7 protected
        xfer(2, 1'b1, 4'h7, 4'hF, 0, 1'b1, 4'h0, "ro.wr7");
        xfer(2, 1'b0, 4'h7, 4'h0, 0, 1'b0, 4'h0, "ro.rd7");
        xfer(2, 1'b1, 4'h6, 4'hE, 0, 1'b1, 4'h0, "ro.wr6");
        xfer(2, 1'b0, 4'h6, 4'h0, 0, 1'b0, 4'h0, "ro.rd6");
        xfer(2, 1'b1, 4'h5, 4'h3, 0, 1'b0, 4'h0, "ro.wr5");
        xfer(2, 1'b0, 4'h5, 4'h0, 0, 1'b0, 4'h3, "ro.rd5");
        idle_cycles(1);

        // Abort: psel dropped in the first access cycle of a write
        sel = 4'b1000; penable = 1'b0; pwrite = 1'b1; paddr = 4'h4; pwdata = 4'h3;
        @(posedge pclk); #1;
        sel = '0; penable = 1'b1;
        @(negedge pclk);
        chk("abort.rdy_c1", 32'(rdy[3]), 32'd0);
        @(posedge pclk); #1;
        bus_idle();
        @(negedge pclk);
        chk("abort.rdy_c2", 32'(rdy[3]), 32'd0);
        @(posedge pclk); #1;
        xfer(3, 1'b0, 4'h4, 4'h0, 2, 1'b0, 4'h0, "abort.rd4");
        xfer(3, 1'b1, 4'h4, 4'h3, 2, 1'b0, 4'h0, "w2.wr4");
        xfer(3, 1'b0, 4'h4, 4'h0, 2, 1'b0, 4'h3, "w2.rd4");
        idle_cycles(1);

        // Back-to-back with no idle cycle, then MSB aliasing
        xfer(0, 1'b1, 4'h0, 4'h9, 0, 1'b0, 4'h0, "b2b.wr0");
        xfer(0, 1'b1, 4'h3, 4'h6, 0, 1'b0, 4'h0, "b2b.wr3");
        xfer(0, 1'b0, 4'h0, 4'h0, 0, 1'b0, 4'h9, "b2b.rd0");
        xfer(0, 1'b0, 4'h3, 4'h0, 0, 1'b0, 4'h6, "b2b.rd3");
        xfer(0, 1'b0, 4'h8, 4'h0, 0, 1'b0, 4'h9, "alias.rd8");
        xfer(0, 1'b0, 4'hB, 4'h0, 0, 1'b0, 4'h6, "alias.rdB");
        idle_cycles(1);

        // Reset asserted in the completion cycle of a three-wait read
        sel = 4'b0010; penable = 1'b0; pwrite = 1'b0; paddr = 4'h2;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (3) begin
            @(posedge pclk); #1;
        end
        @(negedge pclk);
        chk("mrst.rdy_before", 32'(rdy[1]), 32'd1);
        chk("mrst.rd_before",  32'(rd[1]),  32'hA);
        #1 presetn = 1'b0;
        #1;
        chk("mrst.rdy", 32'(rdy[1]), 32'd0);
        chk("mrst.err", 32'(err[1]), 32'd0);
        chk("mrst.rd",  32'(rd[1]),  32'd0);
        @(posedge pclk); #1;
        bus_idle();
        presetn = 1'b1;
        idle_cycles(1);
        xfer(1, 1'b0, 4'h2, 4'h0, 3, 1'b0, 4'h0, "mrst.rd2");
        xfer(0, 1'b0, 4'h0, 4'h0, 0, 1'b0, 4'h0, "mrst.w0rd0");
        xfer(0, 1'b0, 4'h1, 4'h0, 0, 1'b0, 4'h0, "mrst.w0rd1");
        xfer(2, 1'b0, 4'h5, 4'h0, 0, 1'b0, 4'h0, "mrst.rord5");
        xfer(3, 1'b0, 4'h4, 4'h0, 2, 1'b0, 4'h0, "mrst.w2rd4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
